// File: rtl/dmem_model_pkg.sv
// Shared types and constants for the dmem latency model.
// Optional stall injection is enabled by DMEM_STALL_INJECT_EN.
package dmem_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MAX_LATENCY = 15;

  // Counter must hold LATENCY-1 plus up to three stall cycles.
  localparam int CNT_W = $clog2(MAX_LATENCY + 4);

endpackage

// File: rtl/stall_lfsr.sv
// Pseudo-random stall source; only compiled when DMEM_STALL_INJECT_EN is defined.
// Steps once per accepted request and exposes its two low bits as extra wait cycles.
`ifdef DMEM_STALL_INJECT_EN
module stall_lfsr
  import dmem_model_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [1:0] extra
);

  logic [15:0] lfsr_reg;
  logic        feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAPS);
  assign extra    = lfsr_reg[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= SEED;
    end else if (step) begin
      lfsr_reg <= {lfsr_reg[14:0], feedback};
    end
  end

endmodule
`endif

// File: rtl/dmem_latency_model.sv
// Data-memory responder with configurable width, depth and latency, byte-masked writes
// and out-of-range errors. Define DMEM_STALL_INJECT_EN to add 0..3 random wait cycles.
module dmem_latency_model
  import dmem_model_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter int          DEPTH      = 1024,
  parameter int          LATENCY    = 1,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dmem_req,
  input  logic                dmem_we,
  input  logic [XLEN-1:0]     dmem_addr,
  input  logic [XLEN-1:0]     dmem_wdata,
  input  logic [XLEN/8-1:0]   dmem_wmask,
  output logic [XLEN-1:0]     dmem_rdata,
  output logic                dmem_ready,
  output logic                dmem_err,
  output logic                busy
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(LATENCY - 1);

  dmem_state_e            state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   we_reg;
  logic [XLEN-1:OFF_W]    addr_reg;
  logic [XLEN-1:0]        wdata_reg;
  logic [NBYTES-1:0]      wmask_reg;
  logic                   ready_reg, err_reg, rd_sel_reg, busy_reg;

  logic                   accept, commit, mem_we, in_range, busy_next;
  logic                   eff_we;
  logic [XLEN-1:OFF_W]    eff_addr;
  logic [XLEN-1:0]        eff_wdata;
  logic [NBYTES-1:0]      eff_wmask;
  logic [IDX_W-1:0]       eff_idx;
  logic [1:0]             extra;
  logic [CNT_W-1:0]       load_cnt;
  logic                   addr_off_unused;

  logic [XLEN-1:0]        mem [DEPTH];
  logic [XLEN-1:0]        mem_q;

  assign accept = dmem_req && (state_reg == IDLE || state_reg == RESP);

`ifdef DMEM_STALL_INJECT_EN
  stall_lfsr #(.SEED(STALL_SEED)) u_stall_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (accept),
    .extra (extra)
  );
`else
  logic [15:0] seed_unused;
  assign seed_unused = STALL_SEED;
  assign extra       = 2'b00;
`endif

  assign load_cnt = BASE_CNT + {{(CNT_W-2){1'b0}}, extra};

  // With LATENCY=1 the commit edge is the accepting edge, so use the live request there.
  assign eff_we    = accept ? dmem_we    : we_reg;
  assign eff_addr  = accept ? dmem_addr[XLEN-1:OFF_W] : addr_reg;
  assign eff_wdata = accept ? dmem_wdata : wdata_reg;
  assign eff_wmask = accept ? dmem_wmask : wmask_reg;
  assign eff_idx   = eff_addr[OFF_W +: IDX_W];
  assign in_range  = ~|eff_addr[XLEN-1:OFF_W+IDX_W];
  assign addr_off_unused = ^dmem_addr[OFF_W-1:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE, RESP: begin
        if (accept) begin
          cnt_next   = load_cnt;
          state_next = (load_cnt == '0) ? RESP : WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt_reg <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    commit    = (state_next == RESP) && rst_n;
    mem_we    = commit && in_range && eff_we;
    busy_next = (state_reg != IDLE) && !(state_reg == RESP && !accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wmask_reg  <= '0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
      rd_sel_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      if (accept) begin
        we_reg    <= dmem_we;
        addr_reg  <= dmem_addr[XLEN-1:OFF_W];
        wdata_reg <= dmem_wdata;
        wmask_reg <= dmem_wmask;
      end
      ready_reg  <= commit;
      err_reg    <= commit && !in_range;
      rd_sel_reg <= commit && in_range && !eff_we;
      busy_reg   <= busy_next;
    end
  end

  // Contents are intentionally outside reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (eff_wmask[b]) begin
          mem[eff_idx][b*8 +: 8] <= eff_wdata[b*8 +: 8];
        end
      end
    end
    mem_q <= mem[eff_idx];
  end

  assign dmem_rdata = rd_sel_reg ? mem_q : '0;
  assign dmem_ready = ready_reg;
  assign dmem_err   = err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_dmem_latency_model.sv
// Self-checking bench: four instances with LATENCY 1..4, table-driven L=1 vectors,
// back-to-back, reset-abort and stall-repeatability sequences via a scoreboard queue.
module tb_dmem_latency_model;

  logic        clk = 1'b0;
  logic        rst_n_s [4];
  logic        req_s   [4];
  logic        we_s    [4];
  logic [63:0] addr_s  [4];
  logic [63:0] wdata_s [4];
  logic [7:0]  wmask_s [4];
  logic [63:0] rdata_s [4];
  logic        ready_s [4];
  logic        err_s   [4];
  logic        busy_s  [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    dmem_latency_model #(
      .XLEN(64), .DEPTH(1024), .LATENCY(gi + 1), .STALL_SEED(16'hACE1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n_s[gi]),
      .dmem_req   (req_s[gi]),
      .dmem_we    (we_s[gi]),
      .dmem_addr  (addr_s[gi]),
      .dmem_wdata (wdata_s[gi]),
      .dmem_wmask (wmask_s[gi]),
      .dmem_rdata (rdata_s[gi]),
      .dmem_ready (ready_s[gi]),
      .dmem_err   (err_s[gi]),
      .busy       (busy_s[gi])
    );
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic bit lat_ok(input int lat, input int l);
`ifdef DMEM_STALL_INJECT_EN
    return (lat >= l) && (lat <= l + 3);
`else
    return lat == l;
`endif
  endfunction

  task automatic check_lat(input string name, input int lat, input int l);
    total++;
    if (!lat_ok(lat, l)) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, lat, l);
    end
  endtask

  // Called just after a rising edge with the instance idle; returns the same way.
  task automatic txn(input int u, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] mask,
                     input logic [63:0] exp_rd, input logic exp_err, output int lat);
    exp_t e, got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    req_s[u] = 1'b1; we_s[u] = we; addr_s[u] = addr; wdata_s[u] = wdata; wmask_s[u] = mask;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (ready_s[u] || lat >= 30) break;
    end
    req_s[u] = 1'b0;
    got = sb.pop_front();
    if (!ready_s[u]) begin
      total++; bad++;
      $display("FAIL timeout u=%0d addr=%h", u, addr);
    end else begin
      check("rdata", rdata_s[u], got.rdata);
      check("err", {63'd0, err_s[u]}, {63'd0, got.err});
      check_lat("latency", lat, u + 1);
    end
    $display("txn u=%0d we=%0d addr=%h wdata=%h mask=%h rdata=%h err=%0d lat=%0d",
             u, we, addr, wdata, mask, rdata_s[u], err_s[u], lat);
    @(posedge clk); #1;
    check("ready_one_cycle", {63'd0, ready_s[u]}, 64'd0);
  endtask

  task automatic pulse_reset(input int u);
    rst_n_s[u] = 1'b0;
    @(posedge clk); #1;
    rst_n_s[u] = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    int   lat, nready, last, extra_rdy, mism;
    int   lat_a[100];
    exp_t got;

    tbl[0]  = '{1'b1, 64'h40,   64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 64'h40,   64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    tbl[2]  = '{1'b1, 64'h40,   64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    tbl[3]  = '{1'b0, 64'h40,   64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tbl[4]  = '{1'b1, 64'h0,    64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
    tbl[5]  = '{1'b0, 64'h2000, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[6]  = '{1'b1, 64'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
    tbl[7]  = '{1'b0, 64'h0,    64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    tbl[8]  = '{1'b0, 64'h47,   64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tbl[9]  = '{1'b1, 64'h40,   64'h5555555555555555, 8'h00, 64'h0, 1'b0};
    tbl[10] = '{1'b0, 64'h40,   64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tbl[11] = '{1'b1, 64'h40,   64'h0102030405060708, 8'hC3, 64'h0, 1'b0};
    tbl[12] = '{1'b0, 64'h40,   64'h0, 8'h00, 64'h01023344AAAA0708, 1'b0};
    tbl[13] = '{1'b0, 64'h8000000000000040, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[14] = '{1'b1, 64'h1FF8, 64'hFEDCBA9876543210, 8'hFF, 64'h0, 1'b0};
    tbl[15] = '{1'b0, 64'h1FF8, 64'h0, 8'h00, 64'hFEDCBA9876543210, 1'b0};

    for (int u = 0; u < 4; u++) begin
      rst_n_s[u] = 1'b0; req_s[u] = 1'b0; we_s[u] = 1'b0;
      addr_s[u] = '0; wdata_s[u] = '0; wmask_s[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      check("reset_ready", {63'd0, ready_s[u]}, 64'd0);
      check("reset_err",   {63'd0, err_s[u]},   64'd0);
      check("reset_rdata", rdata_s[u],           64'd0);
      check("reset_busy",  {63'd0, busy_s[u]},  64'd0);
      rst_n_s[u] = 1'b1;
    end
    @(posedge clk); #1;

    // Table-driven vectors on the LATENCY=1 instance.
    for (int i = 0; i < 16; i++) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
          tbl[i].exp_rd, tbl[i].exp_err, lat);
    end

    // LATENCY=4: preload four words, then four reads with the request held.
    for (int i = 0; i < 4; i++) begin
      txn(3, 1'b1, 64'h100 + 64'(8 * i), 64'hB0B0000000000000 + 64'(i), 8'hFF, 64'h0, 1'b0, lat);
    end
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{64'hB0B0000000000000 + 64'(i), 1'b0});
    end
    req_s[3] = 1'b1; we_s[3] = 1'b0; addr_s[3] = 64'h100;
    nready = 0; last = 0;
    for (int cyc = 1; cyc <= 60 && nready < 4; cyc++) begin
      @(posedge clk); #1;
      if (nready > 0) check("b2b_busy", {63'd0, busy_s[3]}, 64'd1);
      if (ready_s[3]) begin
        got = sb.pop_front();
        check("b2b_rdata", rdata_s[3], got.rdata);
        check("b2b_err", {63'd0, err_s[3]}, {63'd0, got.err});
        check_lat("b2b_spacing", cyc - last, 4);
        $display("txn u=3 b2b read addr=%h rdata=%h cycle=%0d", addr_s[3], rdata_s[3], cyc);
        last = cyc;
        nready++;
        if (nready < 4) addr_s[3] = 64'h100 + 64'(8 * nready);
        else req_s[3] = 1'b0;
      end
    end
    check("b2b_pulses", 64'(nready), 64'd4);
    extra_rdy = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      if (ready_s[3]) extra_rdy++;
    end
    check("b2b_no_extra_ready", 64'(extra_rdy), 64'd0);
    check("b2b_idle_busy", {63'd0, busy_s[3]}, 64'd0);
    while (sb.size() > 0) void'(sb.pop_front());

    // LATENCY=3: reset one cycle after accepting a write drops it.
    txn(2, 1'b1, 64'h8, 64'h0BADF00D12345678, 8'hFF, 64'h0, 1'b0, lat);
    req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 64'h8;
    wdata_s[2] = 64'hFFFFFFFFFFFFFFFF; wmask_s[2] = 8'hFF;
    @(posedge clk); #1;
    check("abort_ready_wait", {63'd0, ready_s[2]}, 64'd0);
    @(posedge clk); #1;
    rst_n_s[2] = 1'b0;
    req_s[2] = 1'b0;
    #1;
    check("abort_ready", {63'd0, ready_s[2]}, 64'd0);
    check("abort_err",   {63'd0, err_s[2]},   64'd0);
    check("abort_rdata", rdata_s[2],           64'd0);
    check("abort_busy",  {63'd0, busy_s[2]},  64'd0);
    $display("txn u=2 reset asserted during write to addr=%h", addr_s[2]);
    extra_rdy = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready_s[2]) extra_rdy++;
    end
    rst_n_s[2] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready_s[2]) extra_rdy++;
    end
    check("abort_no_ready", 64'(extra_rdy), 64'd0);
    txn(2, 1'b0, 64'h8, 64'h0, 8'h00, 64'h0BADF00D12345678, 1'b0, lat);

    // LATENCY=2: latency sequence must repeat after reset with the same seed.
    mism = 0;
    for (int run = 0; run < 2; run++) begin
      pulse_reset(1);
      txn(1, 1'b1, 64'h40, 64'hC0FFEE0012345678, 8'hFF, 64'h0, 1'b0, lat);
      for (int i = 0; i < 100; i++) begin
        txn(1, 1'b0, 64'h40, 64'h0, 8'h00, 64'hC0FFEE0012345678, 1'b0, lat);
        if (run == 0) lat_a[i] = lat;
        else if (lat != lat_a[i]) mism++;
      end
    end
    check("stall_repeat", 64'(mism), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
